// File: rtl/sdram_port_arb_if.sv
// sdram_port_arb_if: control-port bundle between the port arbiter and sdram_core_pc.
//   master (arbiter side): drives addr, wdata, wr, rd; receives rdy, wvalid, rvalid, rdata.
//   slave  (core side)   : the mirror image.
interface sdram_port_arb_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wr;
  logic                  rd;
  logic                  rdy;
  logic                  wvalid;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output addr, wdata, wr, rd,
    input  rdy, wvalid, rvalid, rdata
  );

  modport slave (
    input  addr, wdata, wr, rd,
    output rdy, wvalid, rvalid, rdata
  );
endinterface

// File: rtl/sdram_port_arb.sv
// sdram_port_arb: round-robin arbiter sharing one sdram_core_pc control port among
// NUM_PORTS requesters. One core operation is outstanding at a time; rdy/wvalid/rvalid
// are routed back only to the port that owns the current operation.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   req_addr_i      packed per-port byte address (port i at [i*ADDR_WIDTH +: ADDR_WIDTH])
//   req_wdata_i     packed per-port write data
//   req_wr_i/rd_i   per-port write/read request, held until req_rdy_o
//   req_rdy_o       accept pulse to the granted port (combinational from the core rdy)
//   req_wvalid_o    write-complete pulse to the owning port
//   req_rvalid_o    read-data-valid pulse to the owning port
//   req_rdata_o     read data, meaningful only with req_rvalid_o
//   sd              master side of the core control port
//   err_o           watchdog abort pulse
//
// Optional feature: define SDRAM_ARB_WDOG_EN to abort an operation that is still
// unfinished TIMEOUT_CYC cycles after entering ISSUE. Without it err_o is tied 0.
module sdram_port_arb #(
  parameter int unsigned NUM_PORTS   = 3,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata_i,
  input  logic [NUM_PORTS-1:0]             req_wr_i,
  input  logic [NUM_PORTS-1:0]             req_rd_i,
  output logic [NUM_PORTS-1:0]             req_rdy_o,
  output logic [NUM_PORTS-1:0]             req_wvalid_o,
  output logic [NUM_PORTS-1:0]             req_rvalid_o,
  output logic [DATA_WIDTH-1:0]            req_rdata_o,
  sdram_port_arb_if.master                 sd,
  output logic                             err_o
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]        grant_q, grant_d;
  logic                    op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0]   sd_addr_q, sd_addr_d;
  logic [DATA_WIDTH-1:0]   sd_wdata_q, sd_wdata_d;
  logic                    sd_wr_q, sd_wr_d;
  logic                    sd_rd_q, sd_rd_d;

  logic [NUM_PORTS-1:0]    pending;
  logic                    pick_vld;
  logic [PTR_W-1:0]        pick_idx;
  logic                    pick_wr;
  logic [ADDR_WIDTH-1:0]   pick_addr;
  logic [DATA_WIDTH-1:0]   pick_wdata;
  logic                    done_c;
  logic                    abort_c;
  logic [PTR_W-1:0]        next_ptr;

  assign pending = req_wr_i | req_rd_i;

  // Completion only counts in WAIT and only for the latched op type.
  assign done_c = (state_q == ST_WAIT) && (op_wr_q ? sd.wvalid : sd.rvalid);

  // Modulo-NUM_PORTS successor of the current owner.
  assign next_ptr = (grant_q == LAST_PORT) ? '0 : grant_q + PTR_W'(1);

`ifdef SDRAM_ARB_WDOG_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             err_q, err_d;
  logic             wdog_hit;

  // Counter is 0 in the first ISSUE cycle, so the hit lands TIMEOUT_CYC cycles after entry.
  assign wdog_hit = (state_q != ST_IDLE) && (wdog_q == CNT_W'(TIMEOUT_CYC - 1));
  assign abort_c  = wdog_hit && !done_c;
  assign err_o    = err_q;
`else
  localparam int unsigned UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;

  assign abort_c = 1'b0;
  assign err_o   = 1'b0;
`endif

  // Round-robin scan: first pending port at or above rr_ptr, otherwise first from 0.
  always_comb begin : arb_scan
    pick_vld   = 1'b0;
    pick_idx   = '0;
    pick_wr    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!pick_vld && pending[i] && (PTR_W'(i) >= rr_ptr_q)) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!pick_vld && pending[i]) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_idx == PTR_W'(i)) begin
        // Write wins when both are asserted; the read stays pending.
        pick_wr    = req_wr_i[i];
        pick_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        pick_wdata = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      op_wr_q    <= 1'b0;
      sd_addr_q  <= '0;
      sd_wdata_q <= '0;
      sd_wr_q    <= 1'b0;
      sd_rd_q    <= 1'b0;
`ifdef SDRAM_ARB_WDOG_EN
      wdog_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      op_wr_q    <= op_wr_d;
      sd_addr_q  <= sd_addr_d;
      sd_wdata_q <= sd_wdata_d;
      sd_wr_q    <= sd_wr_d;
      sd_rd_q    <= sd_rd_d;
`ifdef SDRAM_ARB_WDOG_EN
      wdog_q     <= wdog_d;
      err_q      <= err_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin : fsm_next
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (abort_c)     state_d = ST_IDLE;
        else if (sd.rdy) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_c || abort_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin : fsm_out
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    op_wr_d      = op_wr_q;
    sd_addr_d    = sd_addr_q;
    sd_wdata_d   = sd_wdata_q;
    sd_wr_d      = sd_wr_q;
    sd_rd_d      = sd_rd_q;
    req_rdy_o    = '0;
    req_wvalid_o = '0;
    req_rvalid_o = '0;
    req_rdata_o  = '0;
`ifdef SDRAM_ARB_WDOG_EN
    wdog_d       = (state_q == ST_IDLE) ? '0 : wdog_q + CNT_W'(1);
    err_d        = abort_c;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d    = pick_idx;
          op_wr_d    = pick_wr;
          sd_addr_d  = pick_addr;
          sd_wdata_d = pick_wdata;
          sd_wr_d    = pick_wr;
          sd_rd_d    = !pick_wr;
        end
      end
      ST_ISSUE: begin
        if (abort_c) begin
          sd_wr_d  = 1'b0;
          sd_rd_d  = 1'b0;
          rr_ptr_d = next_ptr;
        end else begin
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == PTR_W'(i)) req_rdy_o[i] = sd.rdy;
          end
          if (sd.rdy) begin
            sd_wr_d = 1'b0;
            sd_rd_d = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (grant_q == PTR_W'(i)) begin
            if (op_wr_q) req_wvalid_o[i] = sd.wvalid;
            else         req_rvalid_o[i] = sd.rvalid;
          end
        end
        if (!op_wr_q) req_rdata_o = sd.rdata;
        if (done_c || abort_c) rr_ptr_d = next_ptr;
      end
      default: ;
    endcase
  end

  assign sd.addr  = sd_addr_q;
  assign sd.wdata = sd_wdata_q;
  assign sd.wr    = sd_wr_q;
  assign sd.rd    = sd_rd_q;

endmodule

// File: tb/tb_sdram_port_arb.sv
// tb_sdram_port_arb: directed bench for sdram_port_arb with a small core model and
// auto-dropping requesters. Events seen by requesters are logged and compared to
// hand-written expected sequences.
module tb_sdram_port_arb;

  localparam int unsigned NP = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  localparam int EV_RDY = 'h10;
  localparam int EV_WV  = 'h20;
  localparam int EV_RV  = 'h30;

  logic              clk;
  logic              rst;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*DW-1:0]  req_wdata;
  logic [NP-1:0]     req_wr;
  logic [NP-1:0]     req_rd;
  logic [NP-1:0]     req_rdy;
  logic [NP-1:0]     req_wvalid;
  logic [NP-1:0]     req_rvalid;
  logic [DW-1:0]     req_rdata;
  logic              err;

  sdram_port_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sd_if ();

  sdram_port_arb #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .req_wr_i(req_wr),
    .req_rd_i(req_rd),
    .req_rdy_o(req_rdy),
    .req_wvalid_o(req_wvalid),
    .req_rvalid_o(req_rvalid),
    .req_rdata_o(req_rdata),
    .sd(sd_if),
    .err_o(err)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          ev_q[$];
  int          op_q[$];
  logic [31:0] rdata_q [NP];
  int          rdy_seen;
  int          multi_rdy;
  int          err_cnt;
  bit          hold_mode;
  int          hold_limit;
  int          core_lat;
  bit          core_hang;
  logic [31:0] mem [64];

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ev_at(input int k);
    if (k < ev_q.size()) return ev_q[k];
    return 'hff;
  endfunction

  function automatic int op_at(input int k);
    if (k < op_q.size()) return op_q[k];
    return 'hff;
  endfunction

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] d);
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*DW +: DW] = d;
  endtask

  task automatic clear_log();
    ev_q.delete();
    op_q.delete();
    rdy_seen = 0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    req_wr = '0;
    req_rd = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for n logged events, then idles a few cycles to expose extras.
  task automatic wait_ev(input string tag, input int n, input int budget);
    int c = 0;
    while (ev_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    check(tag, ev_q.size(), n);
  endtask

  // Core model: rdy the cycle after wr/rd is seen, completion core_lat cycles later.
  initial begin
    logic       m_wr;
    logic [5:0] m_idx;
    logic [31:0] m_dat;
    sd_if.rdy    = 1'b0;
    sd_if.wvalid = 1'b0;
    sd_if.rvalid = 1'b0;
    sd_if.rdata  = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst && (sd_if.wr || sd_if.rd)) begin
        m_wr  = sd_if.wr;
        m_idx = sd_if.addr[7:2];
        m_dat = sd_if.wdata;
        sd_if.rdy = 1'b1;
        @(posedge clk); #1;
        sd_if.rdy = 1'b0;
        if (!core_hang) begin
          repeat (core_lat) @(posedge clk);
          #1;
          if (m_wr) begin
            mem[m_idx]   = m_dat;
            sd_if.wvalid = 1'b1;
          end else begin
            sd_if.rdata  = mem[m_idx];
            sd_if.rvalid = 1'b1;
          end
          @(posedge clk); #1;
          sd_if.wvalid = 1'b0;
          sd_if.rvalid = 1'b0;
        end
      end
    end
  end

  // Requester side: log pulses and drop a request once it is accepted.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if ($countones(req_rdy) > 1) multi_rdy++;
        if (err) err_cnt++;
        for (int i = 0; i < NP; i++) begin
          if (req_rdy[i]) begin
            ev_q.push_back(EV_RDY + i);
            op_q.push_back(int'(sd_if.wr));
            rdy_seen++;
            if (hold_mode) begin
              if (rdy_seen == hold_limit) req_rd = '0;
            end else if (req_wr[i]) begin
              req_wr[i] = 1'b0;
            end else begin
              req_rd[i] = 1'b0;
            end
          end
          if (req_wvalid[i]) ev_q.push_back(EV_WV + i);
          if (req_rvalid[i]) begin
            ev_q.push_back(EV_RV + i);
            rdata_q[i] = req_rdata;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    rst        = 1'b1;
    req_addr   = '0;
    req_wdata  = '0;
    req_wr     = '0;
    req_rd     = '0;
    rdy_seen   = 0;
    multi_rdy  = 0;
    err_cnt    = 0;
    hold_mode  = 1'b0;
    hold_limit = 0;
    core_lat   = 1;
    core_hang  = 1'b0;
    for (int i = 0; i < NP; i++) rdata_q[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_sd_wr", sd_if.wr, 0);
    check("rst_sd_rd", sd_if.rd, 0);
    check("rst_sd_addr", sd_if.addr, 0);
    check("rst_sd_wdata", sd_if.wdata, 0);
    check("rst_req_pulses", {req_rdy, req_wvalid, req_rvalid}, 0);
    check("rst_err", err, 0);

    // Single port: write 0x5 to 0x10 then read it back
    clear_log();
    set_port(0, 32'h10, 32'h5);
    req_wr[0] = 1'b1;
    @(negedge clk);
    check("t1_wr_latency", {sd_if.wr, sd_if.rd}, 2'b10);
    check("t1_wr_addr", sd_if.addr, 32'h10);
    check("t1_wr_wdata", sd_if.wdata, 32'h5);
    wait_ev("t1_wr_count", 2, 50);
    check("t1_wr_ev0", ev_at(0), EV_RDY + 0);
    check("t1_wr_ev1", ev_at(1), EV_WV + 0);
    clear_log();
    req_rd[0] = 1'b1;
    @(negedge clk);
    check("t1_rd_latency", {sd_if.wr, sd_if.rd}, 2'b01);
    check("t1_rd_addr", sd_if.addr, 32'h10);
    wait_ev("t1_rd_count", 2, 50);
    check("t1_rd_ev0", ev_at(0), EV_RDY + 0);
    check("t1_rd_ev1", ev_at(1), EV_RV + 0);
    check("t1_rdata", rdata_q[0], 32'h5);

    // Three simultaneous writes from reset: grants 0,1,2; then readback wraps to 0
    do_reset();
    clear_log();
    core_lat = 0;
    set_port(0, 32'h0, 32'hA);
    set_port(1, 32'h4, 32'hB);
    set_port(2, 32'h8, 32'hC);
    req_wr = 3'b111;
    wait_ev("t2_wr_count", 6, 100);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t2_wr_rdy%0d", k), ev_at(2*k), EV_RDY + k);
      check($sformatf("t2_wr_wv%0d", k), ev_at(2*k+1), EV_WV + k);
    end
    clear_log();
    req_rd = 3'b111;
    wait_ev("t2_rd_count", 6, 100);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t2_rd_rdy%0d", k), ev_at(2*k), EV_RDY + k);
      check($sformatf("t2_rd_rv%0d", k), ev_at(2*k+1), EV_RV + k);
    end
    check("t2_rdata0", rdata_q[0], 32'hA);
    check("t2_rdata1", rdata_q[1], 32'hB);
    check("t2_rdata2", rdata_q[2], 32'hC);

    // Continuous reads on all ports for 9 ops: strict rotation
    clear_log();
    core_lat   = 2;
    hold_mode  = 1'b1;
    hold_limit = 9;
    req_rd     = 3'b111;
    wait_ev("t3_count", 18, 300);
    hold_mode = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("t3_rdy%0d", k), ev_at(2*k), EV_RDY + (k % 3));
      check($sformatf("t3_rv%0d", k), ev_at(2*k+1), EV_RV + (k % 3));
    end

    // Port 1 with wr and rd together: write first, read on a later grant
    clear_log();
    core_lat = 1;
    set_port(1, 32'h20, 32'h77);
    req_wr[1] = 1'b1;
    req_rd[1] = 1'b1;
    wait_ev("t4_count", 4, 100);
    check("t4_ev0", ev_at(0), EV_RDY + 1);
    check("t4_ev1", ev_at(1), EV_WV + 1);
    check("t4_ev2", ev_at(2), EV_RDY + 1);
    check("t4_ev3", ev_at(3), EV_RV + 1);
    check("t4_op0_wr", op_at(0), 1);
    check("t4_op1_rd", op_at(1), 0);
    check("t4_rdata", rdata_q[1], 32'h77);

    // Reset while in WAIT (rr_ptr is 2 beforehand); afterwards port 0 must win over 2
    clear_log();
    core_hang = 1'b1;
    set_port(1, 32'h30, 32'h99);
    req_wr[1] = 1'b1;
    wait_ev("t5_hang_count", 1, 20);
    repeat (5) @(negedge clk);
    check("t5_no_wvalid", ev_q.size(), 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_sd", {sd_if.wr, sd_if.rd}, 2'b00);
    check("t5_rst_pulses", {req_rdy, req_wvalid, req_rvalid}, 0);
    rst       = 1'b0;
    core_hang = 1'b0;
    clear_log();
    set_port(0, 32'h40, 32'h1);
    set_port(2, 32'h44, 32'h2);
    req_wr = 3'b101;
    wait_ev("t5_after_count", 4, 100);
    check("t5_ev0", ev_at(0), EV_RDY + 0);
    check("t5_ev1", ev_at(1), EV_WV + 0);
    check("t5_ev2", ev_at(2), EV_RDY + 2);
    check("t5_ev3", ev_at(3), EV_WV + 2);
    clear_log();
    req_rd[2] = 1'b1;
    wait_ev("t5_rd_count", 2, 50);
    check("t5_rdata", rdata_q[2], 32'h2);

`ifdef SDRAM_ARB_WDOG_EN
    // Watchdog: core never completes port 0's write; err after TO cycles, then port 1
    do_reset();
    clear_log();
    err_cnt   = 0;
    core_hang = 1'b1;
    set_port(0, 32'h50, 32'h5A);
    set_port(1, 32'h54, 32'h5B);
    req_wr = 3'b011;
    c = 0;
    while (!sd_if.wr && c < 10) begin
      @(negedge clk);
      c++;
    end
    c = 0;
    while (!err && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("t6_err_cycle", c, TO);
    core_hang = 1'b0;
    wait_ev("t6_count", 3, 100);
    check("t6_ev0", ev_at(0), EV_RDY + 0);
    check("t6_ev1", ev_at(1), EV_RDY + 1);
    check("t6_ev2", ev_at(2), EV_WV + 1);
    check("t6_err_once", err_cnt, 1);
`else
    check("err_never", err_cnt, 0);
`endif

    check("rdy_onehot", multi_rdy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_port_arb.md
Name: sdram_port_arb

Overview:
- Round-robin arbiter that shares the single `sdram_core_pc` control port among N independent requesters (e.g. CPU, DMA, video).
- Sits between the requesters and the core. Each requester port uses the same handshake as the core's control interface.
- Serialises accesses, one outstanding operation at a time, and routes `rdy`, `wvalid` and `rvalid` back to the owning requester only.

Parameters:
- NUM_PORTS, 3, number of requester ports (2..8)
- ADDR_WIDTH, 32, byte address width, same as the core control interface
- DATA_WIDTH, 32, data width, same as the core control interface
- TIMEOUT_CYC, 1024, watchdog limit in clk cycles (used only with SDRAM_ARB_WDOG_EN)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_addr  in  NUM_PORTS*ADDR_WIDTH  packed per-port address; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_PORTS*DATA_WIDTH  packed per-port write data
- req_wr  in  NUM_PORTS  per-port write request, held until req_rdy
- req_rd  in  NUM_PORTS  per-port read request, held until req_rdy
- req_rdy  out  NUM_PORTS  one-cycle accept pulse to the granted port
- req_wvalid  out  NUM_PORTS  one-cycle write-complete pulse to the owning port
- req_rvalid  out  NUM_PORTS  one-cycle read-data-valid pulse to the owning port
- req_rdata  out  DATA_WIDTH  read data, broadcast to all ports; valid only with req_rvalid
- sd_addr  out  ADDR_WIDTH  to core ctrl addr
- sd_wdata  out  DATA_WIDTH  to core ctrl write_data
- sd_wr  out  1  to core ctrl wr
- sd_rd  out  1  to core ctrl rd
- sd_rdy  in  1  from core ctrl rdy
- sd_wvalid  in  1  from core ctrl wvalid
- sd_rvalid  in  1  from core ctrl rvalid
- sd_rdata  in  DATA_WIDTH  from core ctrl read_data
- err  out  1  watchdog abort pulse (tied 0 when feature is off)

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0, grant=0.
  - sd_wr=0, sd_rd=0, sd_addr=0, sd_wdata=0.
  - req_rdy, req_wvalid, req_rvalid all 0; err=0.
- A port is pending if req_wr[i] or req_rd[i] is high.
- If a port asserts both, the write wins. The read remains pending and is served in a later grant.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any port is pending, select the first pending port scanning rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - Register grant, op (wr/rd), sd_addr and sd_wdata from that port.
  - Set sd_wr or sd_rd, then go to ISSUE.
  - Arbitration latency: sd_wr/sd_rd rise 1 cycle after the request is seen.
- ISSUE:
  - Hold sd_* stable.
  - req_rdy[grant] = sd_rdy (combinational, only in ISSUE).
  - On a cycle with sd_rdy=1, clear sd_wr/sd_rd at the next edge and go to WAIT.
- WAIT:
  - For a write, req_wvalid[grant] = sd_wvalid.
  - For a read, req_rvalid[grant] = sd_rvalid and req_rdata = sd_rdata.
  - On the completion pulse, set rr_ptr=(grant+1) mod NUM_PORTS and return to IDLE.
  - Next arbitration happens in that IDLE cycle, so the minimum gap between core operations is 1 cycle.
- Completion pulses arriving outside WAIT, or not matching the latched op, are ignored and never forwarded.
- Operations are latched at grant. A requester dropping req_wr/req_rd during ISSUE does not cancel the core op. The op completes and the completion pulse is still delivered.
- Ports not granted see req_rdy=0, req_wvalid=0, req_rvalid=0 throughout.
- Fairness: with all ports continuously pending, grants rotate 0,1,...,N-1,0.
- Reset mid-operation: the FSM returns to IDLE and outputs go to reset values on the next edge. The core shares rst, so no recovery sequence is needed.
- rr_ptr wraps with modulo NUM_PORTS arithmetic. It is not a power-of-two wrap.

Optional Feature:
- Macro: SDRAM_ARB_WDOG_EN.
- Defined:
  - A counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - On reaching TIMEOUT_CYC: drop sd_wr/sd_rd, pulse err for 1 cycle, advance rr_ptr past grant, return to IDLE.
  - No rdy/valid is sent to the requester for the aborted op.
- Undefined: no counter; err is tied 0; the FSM waits indefinitely.

Test Plan:
- Single port 0 writes 0x5 to 0x10, then reads 0x10 -> sd_wr then sd_rd asserted with addr 0x10; req_wvalid[0] then req_rvalid[0] fire; req_rdata=0x5; other ports see no pulses.
- Ports 0,1,2 each write simultaneously (data 0xA,0xB,0xC to 0x0,0x4,0x8) -> grants in order 0,1,2; each req_wvalid goes to its owner; readback returns matching data.
- All 3 ports hold continuous reads for 9 ops -> grant sequence 0,1,2,0,1,2,0,1,2; no port is starved.
- Port 1 asserts wr and rd together at 0x20 -> write issued first, read issued on a later grant; req_wvalid[1] precedes req_rvalid[1].
- rst asserted while in WAIT -> next edge: state IDLE, sd_wr=sd_rd=0, rr_ptr=0; a later request from port 2 is served normally.
- With SDRAM_ARB_WDOG_EN and TIMEOUT_CYC=16, a core model that never returns wvalid -> err pulses once at cycle 16 after ISSUE entry; the next pending port is then granted.
